// File: rtl/irq_vrc_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_vrc_multi : multi-channel VRC-style IRQ counter, falling-edge state   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module irq_vrc_multi #(
  parameter int CHANNELS = 2,
  parameter int CTR_W    = 8,
  parameter int SCAN_T1  = 113,
  parameter int SCAN_T2  = 227,
  parameter int SCAN_T3  = 340
) (
  input  logic                cpu_m2,
  input  logic                map_rst_n,
  input  logic                reg_we,
  input  logic [1:0]          ch_sel,
  input  logic [1:0]          reg_sel,
  input  logic [7:0]          cpu_data,
  output logic [7:0]          rd_data,
  output logic [CHANNELS-1:0] irq_vec,
  output logic                irq
);

  localparam logic [8:0] c_t1 = 9'(SCAN_T1);
  localparam logic [8:0] c_t2 = 9'(SCAN_T2);
  localparam logic [8:0] c_t3 = 9'(SCAN_T3);

  logic [CHANNELS*8-1:0] w_rd_flat;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CTR_W-1:0] r_latch;
    logic [CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0] w_latch_nxt;
    logic [CTR_W-1:0] w_hi_data;
    logic [8:0]       r_presc;
    logic             r_a;
    logic             r_e;
    logic             r_m;
    logic             r_o;
    logic             r_pend;
    logic             w_sel;
    logic             w_tick;
    logic [15:0]      w_latch_ext;
    logic [7:0]       w_rd;

    assign w_sel       = reg_we && (ch_sel == 2'(gi));
    assign w_tick      = r_m || (r_presc == c_t1) || (r_presc == c_t2) || (r_presc == c_t3);
    assign w_latch_ext = 16'(r_latch);

    // High latch byte only exists for counters wider than 8 bits.
    if (CTR_W > 8) begin : g_hi
      assign w_hi_data = {cpu_data[CTR_W-9:0], r_latch[7:0]};
    end else begin : g_no_hi
      assign w_hi_data = r_latch;
    end

    always_comb begin
      w_latch_nxt = r_latch;
      if (w_sel && reg_sel == 2'd0) w_latch_nxt[7:0] = cpu_data;
      if (w_sel && reg_sel == 2'd1) w_latch_nxt = w_hi_data;
    end

    // Register writes are placed last so they override the counting update.
    always_ff @(negedge cpu_m2 or negedge map_rst_n) begin
      if (!map_rst_n) begin
        r_latch <= '0;
        r_ctr   <= '0;
        r_presc <= '0;
        r_a     <= 1'b0;
        r_e     <= 1'b0;
        r_m     <= 1'b0;
        r_o     <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        r_latch <= w_latch_nxt;
        if (r_e) begin
          r_presc <= (r_presc == c_t3) ? 9'd0 : r_presc + 9'd1;
          if (w_tick) begin
            if (&r_ctr) begin
              r_ctr  <= r_latch;
              r_pend <= 1'b1;
              if (r_o) r_e <= 1'b0;
            end else begin
              r_ctr <= r_ctr + CTR_W'(1);
            end
          end
        end
        if (w_sel && reg_sel == 2'd2) begin
          {r_o, r_m, r_e, r_a} <= cpu_data[3:0];
          r_pend               <= 1'b0;
          if (cpu_data[1]) begin
            r_ctr   <= r_latch;
            r_presc <= 9'd0;
          end
        end
        if (w_sel && reg_sel == 2'd3) begin
          r_e    <= r_a;
          r_pend <= 1'b0;
        end
      end
    end

    always_comb begin
      case (reg_sel)
        2'd0:    w_rd = w_latch_ext[7:0];
        2'd1:    w_rd = w_latch_ext[15:8];
        2'd2:    w_rd = {3'b000, r_pend, r_o, r_m, r_e, r_a};
        default: w_rd = r_ctr[7:0];
      endcase
    end

    assign w_rd_flat[gi*8 +: 8] = w_rd;
    assign irq_vec[gi]          = r_e & r_pend;
  end

  always_comb begin
    rd_data = 8'hFF;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == 2'(i)) rd_data = w_rd_flat[i*8 +: 8];
    end
  end

  assign irq = |irq_vec;

endmodule
`default_nettype wire
